// File: rtl/lc3_mmio_int_ctl_pkg.sv
// lc3_mmio_int_ctl_pkg: shared LC-3 I/O address map, read-mux select codes and interrupt vectors
package lc3_mmio_int_ctl_pkg;
   localparam logic [15:0] KBSR_ADDR   = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR   = 16'hFE02;
   localparam logic [15:0] DSR_ADDR    = 16'hFE04;
   localparam logic [15:0] DDR_ADDR    = 16'hFE06;
   localparam logic [15:0] SWR_ADDR    = 16'hFE08;
   localparam logic [15:0] SDAER_ADDR  = 16'hFE0A;
   localparam logic [15:0] SDADR_ADDR  = 16'hFE0C;
   localparam logic [15:0] SDA_ADDR    = 16'hFE0E;
   localparam logic [15:0] SCLER_ADDR  = 16'hFE10;
   localparam logic [15:0] SCL_ADDR    = 16'hFE12;
   localparam logic [15:0] UARTSR_ADDR = 16'hFE14;
   localparam logic [15:0] UARTDR_ADDR = 16'hFE16;
   localparam logic [3:0] SEL_MEM    = 4'd0;
   localparam logic [3:0] SEL_KBSR   = 4'd1;
   localparam logic [3:0] SEL_KBDR   = 4'd2;
   localparam logic [3:0] SEL_DSR    = 4'd3;
   localparam logic [3:0] SEL_SWR    = 4'd4;
   localparam logic [3:0] SEL_SDAER  = 4'd5;
   localparam logic [3:0] SEL_SDADR  = 4'd6;
   localparam logic [3:0] SEL_SDA    = 4'd7;
   localparam logic [3:0] SEL_SCLER  = 4'd8;
   localparam logic [3:0] SEL_SCL    = 4'd9;
   localparam logic [3:0] SEL_UARTSR = 4'd10;
   localparam logic [3:0] SEL_NONE   = 4'hF;
   localparam logic [7:0] VEC_NONE = 8'h00;
   localparam logic [7:0] VEC_KB   = 8'h80;
   localparam logic [7:0] VEC_DSP  = 8'h81;
   localparam logic [7:0] VEC_UART = 8'h82;
   localparam logic [7:0] VEC_PRIV = 8'h00;
   localparam logic [7:0] VEC_ILL  = 8'h01;
   localparam logic [7:0] VEC_RSVD = 8'h02;
   typedef enum logic [1:0] {VSRC_INT, VSRC_PRIV, VSRC_ILL, VSRC_RSVD} vsrc_e;
endpackage

// File: rtl/lc3_mmio_int_ctl_arbiter.sv
// lc3_int_arbiter: combinational interrupt request/priority/vector; UART joins only with LC3_UART_INT_EN
module lc3_int_arbiter
   import lc3_mmio_int_ctl_pkg::*;
#(
   parameter int KB_PL   = 4,
   parameter int DSP_PL  = 3,
   parameter int UART_PL = 2
) (
   input  logic [1:0] kb_st,
   input  logic [1:0] dsr_st,
   input  logic [1:0] uart_st,
   output logic [2:0] int_priority,
   output logic [7:0] int_vector
);
   logic kb_req, dsp_req, uart_req;
   assign kb_req  = &kb_st;
   assign dsp_req = &dsr_st;
`ifdef LC3_UART_INT_EN
   assign uart_req = &uart_st;
`else
   logic unused_uart;
   assign uart_req    = 1'b0;
   assign unused_uart = &uart_st;
`endif
   // Higher-ranked sources are evaluated last and win ties with >=
   always_comb begin
      int_priority = 3'd0;
      int_vector   = VEC_NONE;
      if (uart_req) begin
         int_priority = 3'(UART_PL);
         int_vector   = VEC_UART;
      end
      if (dsp_req && 3'(DSP_PL) >= int_priority) begin
         int_priority = 3'(DSP_PL);
         int_vector   = VEC_DSP;
      end
      if (kb_req && 3'(KB_PL) >= int_priority) begin
         int_priority = 3'(KB_PL);
         int_vector   = VEC_KB;
      end
   end
endmodule

// File: rtl/lc3_mmio_int_ctl.sv
// lc3_mmio_int_ctl: LC-3 MMIO address decode, interrupt arbitration and vector register
// Optional LC3_UART_INT_EN lets the UART take part in interrupt arbitration.
module lc3_mmio_int_ctl
   import lc3_mmio_int_ctl_pkg::*;
#(
   parameter int KB_PL   = 4,
   parameter int DSP_PL  = 3,
   parameter int UART_PL = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] mar,
   input  logic        r_w,
   input  logic        mio_en,
   output logic [3:0]  inmux_sel,
   output logic        mem_en,
   output logic        ld_kbsr,
   output logic        ld_ddr,
   output logic        ld_dsr,
   output logic        ld_sdaer,
   output logic        ld_sdadr,
   output logic        ld_scler,
   output logic        ld_uartdr,
   output logic        ld_uartsr,
   input  logic [15:0] kbsr,
   input  logic [15:0] dsr,
   input  logic [15:0] uartsr,
   input  logic [1:0]  vector_mux,
   input  logic        ld_vector,
   output logic [7:0]  vector,
   output logic [2:0]  int_priority
);
   logic       wr, unused_status;
   logic [7:0] int_vector, vec_next;
   vsrc_e      vsrc;
   assign wr            = mio_en & r_w;
   assign mem_en        = mio_en & (mar < KBSR_ADDR);
   assign ld_kbsr       = wr & (mar == KBSR_ADDR);
   assign ld_dsr        = wr & (mar == DSR_ADDR);
   assign ld_ddr        = wr & (mar == DDR_ADDR);
   assign ld_sdaer      = wr & (mar == SDAER_ADDR);
   assign ld_sdadr      = wr & (mar == SDADR_ADDR);
   assign ld_scler      = wr & (mar == SCLER_ADDR);
   assign ld_uartsr     = wr & (mar == UARTSR_ADDR);
   assign ld_uartdr     = wr & (mar == UARTDR_ADDR);
   assign unused_status = ^{kbsr[13:0], dsr[13:0], uartsr[13:0]};
   always_comb begin
      inmux_sel = (mar < KBSR_ADDR) ? SEL_MEM : SEL_NONE;
      case (mar)
         KBSR_ADDR:   inmux_sel = SEL_KBSR;
         KBDR_ADDR:   inmux_sel = SEL_KBDR;
         DSR_ADDR:    inmux_sel = SEL_DSR;
         SWR_ADDR:    inmux_sel = SEL_SWR;
         SDAER_ADDR:  inmux_sel = SEL_SDAER;
         SDADR_ADDR:  inmux_sel = SEL_SDADR;
         SDA_ADDR:    inmux_sel = SEL_SDA;
         SCLER_ADDR:  inmux_sel = SEL_SCLER;
         SCL_ADDR:    inmux_sel = SEL_SCL;
         UARTSR_ADDR: inmux_sel = SEL_UARTSR;
         default:     ;
      endcase
   end
   lc3_int_arbiter #(.KB_PL(KB_PL), .DSP_PL(DSP_PL), .UART_PL(UART_PL)) u_arb (
      .kb_st       (kbsr[15:14]),
      .dsr_st      (dsr[15:14]),
      .uart_st     (uartsr[15:14]),
      .int_priority(int_priority),
      .int_vector  (int_vector)
   );
   assign vsrc     = vsrc_e'(vector_mux);
   assign vec_next = vsrc == VSRC_INT  ? int_vector :
                     vsrc == VSRC_PRIV ? VEC_PRIV :
                     vsrc == VSRC_ILL  ? VEC_ILL : VEC_RSVD;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         vector <= VEC_NONE;
      else if (ld_vector)
         vector <= vec_next;
endmodule

// File: tb/tb_lc3_mmio_int_ctl.sv
// tb_lc3_mmio_int_ctl: scoreboard bench with a table-driven reference model of decode and arbitration
module tb_lc3_mmio_int_ctl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic [15:0] mar = '0, kbsr = '0, dsr = '0, uartsr = '0;
   logic        r_w = 1'b0, mio_en = 1'b0, ld_vector = 1'b0;
   logic [1:0]  vector_mux = '0;
   logic [3:0]  inmux_sel;
   logic        mem_en, ld_kbsr, ld_ddr, ld_dsr, ld_sdaer, ld_sdadr, ld_scler, ld_uartdr, ld_uartsr;
   logic [7:0]  vector;
   logic [2:0]  int_priority;
   int checks = 0, failures = 0;

   lc3_mmio_int_ctl #(.KB_PL(4), .DSP_PL(3), .UART_PL(2)) dut (
      .clk(clk), .rst_n(rst_n), .mar(mar), .r_w(r_w), .mio_en(mio_en),
      .inmux_sel(inmux_sel), .mem_en(mem_en),
      .ld_kbsr(ld_kbsr), .ld_ddr(ld_ddr), .ld_dsr(ld_dsr), .ld_sdaer(ld_sdaer),
      .ld_sdadr(ld_sdadr), .ld_scler(ld_scler), .ld_uartdr(ld_uartdr), .ld_uartsr(ld_uartsr),
      .kbsr(kbsr), .dsr(dsr), .uartsr(uartsr), .vector_mux(vector_mux),
      .ld_vector(ld_vector), .vector(vector), .int_priority(int_priority)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] sel;
      logic       mem;
      logic [7:0] ld;
      logic [2:0] pri;
      logic [7:0] vec;
   } exp_t;
   exp_t sb[$];

   // Address map rows: address, read select, strobe bit (-1 = read-only)
   typedef struct {logic [15:0] a; logic [3:0] s; int ld;} map_t;
   map_t io_map[12] = '{
      '{16'hFE00, 4'd1, 0}, '{16'hFE02, 4'd2, -1}, '{16'hFE04, 4'd3, 2}, '{16'hFE06, 4'hF, 1},
      '{16'hFE08, 4'd4, -1}, '{16'hFE0A, 4'd5, 3}, '{16'hFE0C, 4'd6, 4}, '{16'hFE0E, 4'd7, -1},
      '{16'hFE10, 4'd8, 5}, '{16'hFE12, 4'd9, -1}, '{16'hFE14, 4'd10, 7}, '{16'hFE16, 4'hF, 6}};
   int         src_pl[3]  = '{4, 3, 2};
   logic [7:0] src_vec[3] = '{8'h80, 8'h81, 8'h82};
   logic [7:0] model_vec = 8'h00;

   function automatic void arbitrate(input logic [15:0] k, d, u, output logic [2:0] pri, output logic [7:0] vec);
      logic [2:0] req;
      req[0] = k[15] & k[14];
      req[1] = d[15] & d[14];
`ifdef LC3_UART_INT_EN
      req[2] = u[15] & u[14];
`else
      req[2] = 1'b0;
`endif
      pri = 3'd0;
      vec = 8'h00;
      for (int i = 0; i < 3; i++)
         if (req[i] && src_pl[i] > int'(pri)) begin
            pri = 3'(src_pl[i]);
            vec = src_vec[i];
         end
   endfunction

   function automatic exp_t model(input logic [15:0] m, input logic rw, en, input logic [15:0] k, d, u);
      exp_t e;
      e.sel = m < 16'hFE00 ? 4'd0 : 4'hF;
      e.mem = en && m < 16'hFE00;
      e.ld  = '0;
      for (int i = 0; i < 12; i++)
         if (m == io_map[i].a) begin
            e.sel = io_map[i].s;
            if (io_map[i].ld >= 0 && en && rw) e.ld[io_map[i].ld] = 1'b1;
         end
      arbitrate(k, d, u, e.pri, e.vec);
      return e;
   endfunction

   function automatic logic [7:0] vec_src(input logic [1:0] vm, input logic [15:0] k, d, u);
      logic [2:0] p;
      logic [7:0] v;
      arbitrate(k, d, u, p, v);
      return vm == 2'd0 ? v : vm == 2'd1 ? 8'h00 : vm == 2'd2 ? 8'h01 : 8'h02;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the vector model loads on the edge using pre-edge inputs
   task automatic drive(input logic [15:0] m, input logic rw, en, input logic [15:0] k, d, u,
                        input logic [1:0] vm, input logic ld);
      exp_t e;
      @(posedge clk);
      if (ld_vector) model_vec = vec_src(vector_mux, kbsr, dsr, uartsr);
      #1;
      mar = m; r_w = rw; mio_en = en; kbsr = k; dsr = d; uartsr = u; vector_mux = vm; ld_vector = ld;
      e = model(m, rw, en, k, d, u);
      e.vec = model_vec;
      sb.push_back(e);
   endtask

   always @(negedge clk)
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("inmux_sel", 32'(inmux_sel), 32'(e.sel));
         chk("mem_en", 32'(mem_en), 32'(e.mem));
         chk("ld_strobes", 32'({ld_uartsr, ld_uartdr, ld_scler, ld_sdadr, ld_sdaer, ld_dsr, ld_ddr, ld_kbsr}), 32'(e.ld));
         chk("int_priority", 32'(int_priority), 32'(e.pri));
         chk("vector", 32'(vector), 32'(e.vec));
      end

   function automatic logic [15:0] rand_st();
      logic [15:0] s;
      s = 16'($urandom);
      if ($urandom_range(0, 1) == 1) s[15:14] = 2'b11;
      return s;
   endfunction

   function automatic logic [15:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return 16'($urandom_range(0, 16'hFDFF));
         1:       return 16'hFE00 + 16'($urandom_range(0, 11) * 2);
         2:       return 16'hFE00 + 16'($urandom_range(0, 31));
         default: return 16'($urandom_range(16'hFE00, 16'hFFFF));
      endcase
   endfunction

   initial begin
      #2 chk("reset_vector", 32'(vector), 32'h00);
      #10 rst_n = 1'b1;
      drive(16'h3000, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      drive(16'hFE04, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      drive(16'hFE04, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      drive(16'hFE06, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      drive(16'hFE20, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      drive(16'hFDFF, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      drive(16'hFE16, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      drive(16'h0000, 1'b0, 1'b1, 16'hC000, 16'hC000, 16'h0, 2'd0, 1'b1);
      drive(16'h0000, 1'b0, 1'b1, 16'h8000, 16'hC000, 16'h0, 2'd0, 1'b1);
      drive(16'h0000, 1'b0, 1'b1, 16'h0, 16'h0, 16'hC000, 2'd0, 1'b1);
      drive(16'h0000, 1'b0, 1'b1, 16'h0, 16'h0, 16'hC000, 2'd0, 1'b0);
      drive(16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2'd2, 1'b1);
      drive(16'h0000, 1'b0, 1'b0, 16'hC000, 16'hC000, 16'hC000, 2'd0, 1'b0);
      drive(16'h0000, 1'b0, 1'b0, 16'h4000, 16'h8000, 16'h0, 2'd3, 1'b0);
      for (int n = 0; n < 600; n++)
         drive(rand_addr(), 1'($urandom), 1'($urandom), rand_st(), rand_st(), rand_st(),
               2'($urandom), $urandom_range(0, 2) == 0);
      drive(16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2'd3, 1'b1);
      drive(16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2'd3, 1'b0);
      for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_vector", 32'(vector), 32'h00);
      model_vec = 8'h00;
      ld_vector = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      drive(16'h1234, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      drive(16'h1234, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
      for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
      chk("final_drain", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
